// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IF/LS arbiter for the byte-wide RAM/IO port; little-endian bursts, one byte per cycle, done pulse k+1 cycles after grant.
// Backpressure: rdy=0 freezes all state; define IO_BACKPRESSURE_EN to stall IO-region writes while io_buffer_full is high.
module mem_arbiter #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_sig,
    input  logic        load_or_store,
    input  logic [2:0]  len,
    input  logic [31:0] ls_addr,
    input  logic [31:0] store_val,
    output logic        ls_done,
    output logic [31:0] ls_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_first;
    logic        r_last_ls;
    logic        r_serve_if;
    logic [2:0]  r_len;
    logic [2:0]  r_cnt;
    logic [31:0] r_mem_a;
    logic [7:0]  r_mem_dout;
    logic        r_mem_wr;
    logic [23:0] r_wdat;
    logic [31:0] r_rbuf;
    logic        r_if_done;
    logic        r_ls_done;
    logic [31:0] r_if_data;
    logic [31:0] r_ls_data;

    logic        w_grant;
    logic        w_grant_if;
    logic        w_store_grant;
    logic        w_last;
    logic        w_stall;
    logic [31:0] w_rword;

    // Tie: IF wins on the very first grant after reset, afterwards whoever was not served last.
    assign w_grant_if    = if_req & (~ls_sig | r_first | r_last_ls);
    assign w_grant       = (r_state == S_IDLE) & ~clear & (if_req | ls_sig);
    assign w_store_grant = w_grant & ~w_grant_if & load_or_store;
    assign w_last        = (r_cnt == r_len - 3'd1);
    assign w_rword       = r_rbuf | (32'(mem_din) << {r_cnt[1:0], 3'b000});

`ifdef IO_BACKPRESSURE_EN
    assign w_stall = (r_state == S_WRITE) & (r_mem_a[17:16] == IO_ADDR_HI) & io_buffer_full;
`else
    logic w_unused_io;
    assign w_stall     = 1'b0;
    assign w_unused_io = io_buffer_full & (r_mem_a[17:16] == IO_ADDR_HI);
`endif

    assign mem_wr   = r_mem_wr & rdy & ~w_stall;
    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    assign if_done  = r_if_done;
    assign if_data  = r_if_data;
    assign ls_done  = r_ls_done;
    assign ls_data  = r_ls_data;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else if (rdy)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = w_store_grant ? S_WRITE : S_READ;
            S_READ:  if (clear) w_next = S_IDLE;
                     else if (w_last) w_next = S_DONE;
            // Committed stores ignore clear and always run to completion.
            S_WRITE: if (!w_stall && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first    <= 1'b1;
            r_last_ls  <= 1'b0;
            r_serve_if <= 1'b1;
            r_len      <= 3'd0;
            r_cnt      <= 3'd0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_mem_wr   <= 1'b0;
            r_wdat     <= 24'd0;
            r_rbuf     <= 32'd0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= 32'd0;
            r_ls_data  <= 32'd0;
        end else if (rdy) begin
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_first    <= 1'b0;
                        r_last_ls  <= ~w_grant_if;
                        r_serve_if <= w_grant_if;
                        r_len      <= w_grant_if ? 3'd4 : len;
                        r_cnt      <= 3'd0;
                        r_mem_a    <= w_grant_if ? if_addr : ls_addr;
                        r_rbuf     <= 32'd0;
                        r_mem_wr   <= w_store_grant;
                        if (w_store_grant) begin
                            r_mem_dout <= store_val[7:0];
                            r_wdat     <= store_val[31:8];
                        end
                    end
                end
                S_READ: begin
                    if (!clear) begin
                        r_rbuf <= w_rword;
                        if (w_last) begin
                            if (r_serve_if) begin
                                r_if_data <= w_rword;
                                r_if_done <= 1'b1;
                            end else begin
                                r_ls_data <= w_rword;
                                r_ls_done <= 1'b1;
                            end
                        end else begin
                            r_cnt   <= r_cnt + 3'd1;
                            r_mem_a <= r_mem_a + 32'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (!w_stall) begin
                        if (w_last) begin
                            r_mem_wr  <= 1'b0;
                            r_ls_done <= 1'b1;
                        end else begin
                            r_cnt      <= r_cnt + 3'd1;
                            r_mem_a    <= r_mem_a + 32'd1;
                            r_mem_dout <= r_wdat[7:0];
                            r_wdat     <= {8'h00, r_wdat[23:8]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle, plus directed literal checks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_sig, load_or_store;
    logic [2:0]  len;
    logic [31:0] ls_addr, store_val;
    logic        ls_done;
    logic [31:0] ls_data;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_sig(ls_sig), .load_or_store(load_or_store), .len(len), .ls_addr(ls_addr),
        .store_val(store_val), .ls_done(ls_done), .ls_data(ls_data),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // Environment RAM (driven by the DUT) and the model's own copy of memory.
    logic [7:0] phys [0:4095];
    logic [7:0] mram [0:4095];
    assign mem_din = phys[mem_a[11:0]];

    always @(posedge clk) if (mem_wr) phys[mem_a[11:0]] = mem_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        phys[a[11:0]] = b;
        mram[a[11:0]] = b;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int          m_ph;          // 0 idle, 1 burst, 2 done
    bit          m_store, m_if, m_first, m_last_if, started;
    int          m_k, m_i;
    logic [31:0] m_base, m_a, m_wdat, m_ifdat, m_lsdat;
    logic [7:0]  m_dout;
    logic        m_ifd, m_lsd;

    function automatic bit stall_now;
`ifdef IO_BACKPRESSURE_EN
        return (m_ph == 1) && m_store && (m_a[17:16] == 2'b11) && io_buffer_full;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        bit          win_if;
        logic [31:0] word;
        if (rst) begin
            started = 1; m_ph = 0; m_first = 1; m_last_if = 1; m_store = 0; m_if = 1;
            m_a = 0; m_dout = 0; m_ifd = 0; m_lsd = 0; m_ifdat = 0; m_lsdat = 0;
            m_k = 0; m_i = 0; m_base = 0; m_wdat = 0;
        end else if (rdy) begin
            m_ifd = 0;
            m_lsd = 0;
            case (m_ph)
                0: if (!clear && (if_req || ls_sig)) begin
                    win_if    = if_req && (!ls_sig || m_first || !m_last_if);
                    m_first   = 0;
                    m_last_if = win_if;
                    m_if      = win_if;
                    m_store   = !win_if && load_or_store;
                    m_k       = win_if ? 4 : int'(len);
                    m_base    = win_if ? if_addr : ls_addr;
                    m_a       = m_base;
                    m_i       = 0;
                    m_wdat    = store_val;
                    if (m_store) m_dout = store_val[7:0];
                    m_ph = 1;
                end
                1: if (!m_store && clear) begin
                    m_ph = 0;
                end else if (!stall_now()) begin
                    if (m_store) mram[m_a[11:0]] = m_wdat[8*m_i +: 8];
                    if (m_i == m_k - 1) begin
                        m_ph = 2;
                        if (m_store) m_lsd = 1;
                        else begin
                            word = 0;
                            for (int j = 0; j < m_k; j++)
                                word = word | (32'(mram[12'(m_base + 32'(j))]) << (8 * j));
                            if (m_if) begin m_ifd = 1; m_ifdat = word; end
                            else      begin m_lsd = 1; m_lsdat = word; end
                        end
                    end else begin
                        m_i++;
                        m_a = m_a + 1;
                        m_dout = m_wdat[8*m_i +: 8];
                    end
                end
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        bit exp_wr;
        if (started) begin
            exp_wr = (m_ph == 1) && m_store && rdy && !stall_now();
            chk("cyc_mem_wr", 32'(mem_wr), 32'(exp_wr));
            chk("cyc_mem_a", mem_a, m_a);
            if (exp_wr) chk("cyc_mem_dout", 32'(mem_dout), 32'(m_dout));
            chk("cyc_if_done", 32'(if_done), 32'(m_ifd));
            chk("cyc_ls_done", 32'(ls_done), 32'(m_lsd));
            chk("cyc_if_data", if_data, m_ifdat);
            chk("cyc_ls_data", ls_data, m_lsdat);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_done(input bit want_if, output int n);
        bit ok = 0;
        n = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (want_if ? if_done : ls_done) begin ok = 1; n = c; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: no %s pulse within 30 cycles", want_if ? "if_done" : "ls_done");
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] l, output logic [31:0] d);
        int n;
        tick;
        ls_sig = 1; load_or_store = 0; len = l; ls_addr = a;
        wait_done(1'b0, n);
        d = ls_data;
        tick;
        ls_sig = 0;
    endtask

    initial begin
        logic [7:0]  sw_b [4];
        logic [31:0] d;
        int          seq [$];
        int          n;

        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  sw_b [4];
        logic [31:0] d;
        int          seq [$];
        int          n;

        for (int i = 0; i < 4096; i++) begin
            phys[i] = 8'(i) ^ 8'h5A;
            mram[i] = 8'(i) ^ 8'h5A;
        end
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'hA0); poke(32'h103, 8'h00);
        poke(32'h20, 8'h80);
        poke(32'h80, 8'h01); poke(32'h81, 8'h02); poke(32'h82, 8'h03); poke(32'h83, 8'h04);
        poke(32'hFFFF_FFFF, 8'h34); poke(32'h0, 8'h12);

        rst = 1; rdy = 1; clear = 0; io_buffer_full = 0;
        store_val = 0;
        if_req = 1; if_addr = 32'h100;
        ls_sig = 1; load_or_store = 0; len = 3'd1; ls_addr = 32'h20;
        repeat (3) tick;
        @(negedge clk);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_ls_done", 32'(ls_done), 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_ls_data", ls_data, 32'h0);
        tick;
        rst = 0;

        // Both requesters held from reset: IF, LS, IF, LS.
        for (int c = 0; c < 60 && seq.size() < 4; c++) begin
            @(negedge clk);
            if (if_done) seq.push_back(0);
            if (ls_done) seq.push_back(1);
        end
        if (seq.size() < 4) begin
            n_cmp++; n_err++;
            $display("FAIL rr_timeout: %0d grants seen, 4 required", seq.size());
        end else begin
            for (int i = 0; i < 4; i++) chk("rr_order", 32'(seq[i]), 32'(i % 2));
        end
        tick;
        if_req = 0; ls_sig = 0;
        repeat (2) tick;

        // Fetch 0x100: four successive addresses, then one-cycle done.
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fetch_mem_a", mem_a, 32'h100 + 32'(i));
            chk("fetch_done_early", 32'(if_done), 32'h0);
        end
        @(negedge clk);
        chk("fetch_done", 32'(if_done), 32'h1);
        chk("fetch_data", if_data, 32'h00A0_0513);
        tick;
        if_req = 0;
        @(negedge clk);
        chk("fetch_done_once", 32'(if_done), 32'h0);
        repeat (2) tick;

        // LB 0x20: done in the second cycle after the grant edge.
        ls_sig = 1; load_or_store = 0; len = 3'd1; ls_addr = 32'h20;
        @(negedge clk);
        @(negedge clk);
        chk("lb_mem_a", mem_a, 32'h20);
        chk("lb_done_early", 32'(ls_done), 32'h0);
        @(negedge clk);
        chk("lb_done", 32'(ls_done), 32'h1);
        chk("lb_data", ls_data, 32'h0000_0080);
        tick;
        ls_sig = 0;
        repeat (2) tick;

        // SW 0x40 DEADBEEF; inputs change mid-burst and must not matter.
        sw_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ls_sig = 1; load_or_store = 1; len = 3'd4; ls_addr = 32'h40; store_val = 32'hDEAD_BEEF;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sw_mem_wr", 32'(mem_wr), 32'h1);
            chk("sw_mem_a", mem_a, 32'h40 + 32'(i));
            chk("sw_mem_dout", 32'(mem_dout), 32'(sw_b[i]));
            if (i == 0) begin ls_addr = 32'h0; store_val = 32'h0; end
        end
        @(negedge clk);
        chk("sw_done", 32'(ls_done), 32'h1);
        chk("sw_wr_off", 32'(mem_wr), 32'h0);
        tick;
        ls_sig = 0;
        @(negedge clk);
        chk("sw_wr_after", 32'(mem_wr), 32'h0);
        do_load(32'h40, 3'd4, d);
        chk("sw_readback", d, 32'hDEAD_BEEF);

        // LW aborted by clear during byte 1; IDLE accepts a new request next cycle.
        tick;
        ls_sig = 1; load_or_store = 0; len = 3'd4; ls_addr = 32'h80;
        tick;
        tick;
        clear = 1; ls_sig = 0;
        tick;
        clear = 0; ls_sig = 1; len = 3'd1; ls_addr = 32'h20;
        @(negedge clk);
        chk("lw_clr_no_done", 32'(ls_done), 32'h0);
        chk("lw_clr_mem_a", mem_a, 32'h81);
        @(negedge clk);
        chk("lw_clr_next_a", mem_a, 32'h20);
        @(negedge clk);
        chk("lw_clr_next_done", 32'(ls_done), 32'h1);
        chk("lw_clr_next_data", ls_data, 32'h0000_0080);
        tick;
        ls_sig = 0;
        repeat (2) tick;

        // SW with clear during byte 1: all bytes still written, done on schedule.
        ls_sig = 1; load_or_store = 1; len = 3'd4; ls_addr = 32'h50; store_val = 32'h1122_3344;
        tick;
        tick;
        clear = 1;
        tick;
        clear = 0;
        wait_done(1'b0, n);
        chk("sw_clr_done_cycle", 32'(n), 32'd2);
        tick;
        ls_sig = 0;
        do_load(32'h50, 3'd4, d);
        chk("sw_clr_readback", d, 32'h1122_3344);

        // clear in IDLE blocks grants.
        tick;
        clear = 1; if_req = 1; if_addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("clr_idle_mem_a", mem_a, 32'h53);
            if (i < 2) tick;
        end
        tick;
        clear = 0;
        wait_done(1'b1, n);
        chk("clr_idle_fetch", if_data, 32'h00A0_0513);
        tick;
        if_req = 0;
        repeat (2) tick;

        // SH with rdy low for two cycles mid-burst.
        ls_sig = 1; load_or_store = 1; len = 3'd2; ls_addr = 32'h60; store_val = 32'h0000_A5C3;
        tick;
        rdy = 0;
        @(negedge clk);
        chk("rdy_wr_forced", 32'(mem_wr), 32'h0);
        tick;
        @(negedge clk);
        chk("rdy_wr_held", 32'(mem_wr), 32'h0);
        chk("rdy_mem_a", mem_a, 32'h60);
        tick;
        rdy = 1;
        @(negedge clk);
        chk("rdy_resume_wr", 32'(mem_wr), 32'h1);
        chk("rdy_resume_dout", 32'(mem_dout), 32'hC3);
        wait_done(1'b0, n);
        tick;
        ls_sig = 0;
        do_load(32'h60, 3'd2, d);
        chk("sh_readback", d, 32'h0000_A5C3);

        // LH across the 32-bit address wrap.
        do_load(32'hFFFF_FFFF, 3'd2, d);
        chk("wrap_data", d, 32'h0000_1234);
        repeat (2) tick;

        // SB to the IO region while io_buffer_full is high for three cycles.
        ls_sig = 1; load_or_store = 1; len = 3'd1; ls_addr = 32'h0003_0000; store_val = 32'h77;
        io_buffer_full = 1;
        @(negedge clk);
`ifdef IO_BACKPRESSURE_EN
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick;
            @(negedge clk);
            chk("io_stall_wr", 32'(mem_wr), 32'h0);
        end
        tick;
        io_buffer_full = 0;
        @(negedge clk);
        chk("io_resume_wr", 32'(mem_wr), 32'h1);
        chk("io_resume_a", mem_a, 32'h0003_0000);
        @(negedge clk);
        chk("io_done", 32'(ls_done), 32'h1);
`else
        @(negedge clk);
        chk("io_nostall_wr", 32'(mem_wr), 32'h1);
        chk("io_nostall_a", mem_a, 32'h0003_0000);
        chk("io_nostall_dout", 32'(mem_dout), 32'h77);
        @(negedge clk);
        chk("io_done", 32'(ls_done), 32'h1);
`endif
        tick;
        ls_sig = 0; io_buffer_full = 0;
        repeat (3) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
